// File: rtl/sim_pc_checkpoint_monitor.sv
// Retirement-PC checkpoint monitor.
// NCHAN independent channels each watch for the Nth retirement of a given PC,
// then compare a probed data word against an expected value under a mask.
// The run ends in PASS when every enabled channel has checked OK, in FAIL on
// the first mismatch, or in TIMEOUT when the RUN cycle budget is exhausted.
// Terminal flags are sticky until the next start pulse or reset.
module sim_pc_checkpoint_monitor #(
   parameter int unsigned               NCHAN      = 4,
   parameter int unsigned               PC_W       = 32,
   parameter int unsigned               DATA_W     = 32,
   parameter int unsigned               HIT_W      = 8,
   parameter int unsigned               TMO_W      = 24,
   parameter logic [TMO_W-1:0]          TMO_CYCLES = 24'hFFFFFF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      pc_valid,
   input  logic [PC_W-1:0]           pc_w,
   input  logic [NCHAN*DATA_W-1:0]   chk_data,
   input  logic [NCHAN-1:0]          cfg_chan_en,
   input  logic [NCHAN*PC_W-1:0]     cfg_addr,
   input  logic [NCHAN*DATA_W-1:0]   cfg_expect,
   input  logic [NCHAN*DATA_W-1:0]   cfg_mask,
   input  logic [NCHAN*HIT_W-1:0]    cfg_hit_target,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic                      timeout,
   output logic [2:0]                fail_chan,
   output logic [NCHAN-1:0]          chan_done,
   output logic [TMO_W-1:0]          cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   // Last RUN cycle index before the timeout fires; unused when TMO_CYCLES is 0.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - 1'b1;

   state_t                 state;
   logic [NCHAN-1:0]       en_q;
   logic [HIT_W-1:0]       hit_cnt   [NCHAN];

   logic [HIT_W-1:0]       cnt_nxt   [NCHAN];
   logic [NCHAN-1:0]       done_nxt;
   logic [NCHAN-1:0]       mismatch;
   logic [2:0]             fail_idx;

   // Occurrence count (before increment) at which the check fires; 0 acts as 1.
   function automatic logic [HIT_W-1:0] last_hit(input logic [HIT_W-1:0] target);
      return (target == '0) ? '0 : target - 1'b1;
   endfunction

   // Masked compare: only bits set in the mask must agree.
   function automatic logic data_ok(input logic [DATA_W-1:0] data,
                                    input logic [DATA_W-1:0] expect_val,
                                    input logic [DATA_W-1:0] mask);
      return ((data ^ expect_val) & mask) == '0;
   endfunction

   // Per-channel hit detection, occurrence counting and masked data check.
   always_comb begin
      // NOTE: every signal gets a default before the loop so no path leaves a
      // value unassigned, which would otherwise infer a latch.
      done_nxt = chan_done;
      mismatch = '0;
      fail_idx = '0;
      for (int i = 0; i < NCHAN; i++) begin
         cnt_nxt[i] = hit_cnt[i];
      end
      // Walk from the top index down so the lowest mismatching channel wins.
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if ((state == S_RUN) && pc_valid && en_q[i] && !chan_done[i] &&
             (pc_w == cfg_addr[i*PC_W +: PC_W])) begin
            if (hit_cnt[i] != '1) begin
               cnt_nxt[i] = hit_cnt[i] + 1'b1;
            end
            if (hit_cnt[i] == last_hit(cfg_hit_target[i*HIT_W +: HIT_W])) begin
               if (data_ok(chk_data[i*DATA_W +: DATA_W],
                           cfg_expect[i*DATA_W +: DATA_W],
                           cfg_mask[i*DATA_W +: DATA_W])) begin
                  done_nxt[i] = 1'b1;
               end else begin
                  mismatch[i] = 1'b1;
                  fail_idx    = 3'(i);
               end
            end
         end
      end
   end

   // Monitor FSM: start/restart, RUN bookkeeping and terminal-state selection.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         en_q      <= '0;
         chan_done <= '0;
         fail_chan <= '0;
         cycle_cnt <= '0;
         // NOTE: the hit counters are a small register array, not a RAM, so
         // they are reset explicitly; a stale count would corrupt the next run.
         for (int i = 0; i < NCHAN; i++) begin
            hit_cnt[i] <= '0;
         end
      end else if (start) begin
         state     <= S_RUN;
         en_q      <= cfg_chan_en;
         chan_done <= '0;
         fail_chan <= '0;
         cycle_cnt <= '0;
         for (int i = 0; i < NCHAN; i++) begin
            hit_cnt[i] <= '0;
         end
      end else if (state == S_RUN) begin
         hit_cnt   <= cnt_nxt;
         chan_done <= done_nxt;
         if (mismatch != '0) begin
            state     <= S_FAIL;
            fail_chan <= fail_idx;
         end else if ((done_nxt & en_q) == en_q) begin
            state <= S_PASS;
         end else if ((TMO_CYCLES != '0) && (cycle_cnt == TMO_LAST)) begin
            state <= S_TIMEOUT;
         end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
         end
      end
   end

   assign busy    = (state == S_RUN);
   assign pass    = (state == S_PASS);
   assign timeout = (state == S_TIMEOUT);
   assign fail    = (state == S_FAIL) || (state == S_TIMEOUT);
   assign done    = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);

endmodule

// File: tb/tb_sim_pc_checkpoint_monitor.sv
// Directed bench for sim_pc_checkpoint_monitor: expected terminal results are
// queued when each scenario is driven and popped when the monitor reports done.
module tb_sim_pc_checkpoint_monitor;

   localparam int NCHAN  = 4;
   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int HIT_W  = 8;
   localparam int TMO_W  = 24;

   typedef struct {
      logic       pass;
      logic       fail;
      logic       timeout;
      logic [2:0] fail_chan;
      logic [3:0] chan_done;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic                    pc_valid;
   logic [PC_W-1:0]         pc_w;
   logic [NCHAN*DATA_W-1:0] chk_data;
   logic [NCHAN-1:0]        cfg_chan_en;
   logic [NCHAN*PC_W-1:0]   cfg_addr;
   logic [NCHAN*DATA_W-1:0] cfg_expect;
   logic [NCHAN*DATA_W-1:0] cfg_mask;
   logic [NCHAN*HIT_W-1:0]  cfg_hit_target;
   logic                    busy;
   logic                    done;
   logic                    pass;
   logic                    fail;
   logic                    timeout;
   logic [2:0]              fail_chan;
   logic [NCHAN-1:0]        chan_done;
   logic [TMO_W-1:0]        cycle_cnt;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   sim_pc_checkpoint_monitor #(
      .NCHAN      (NCHAN),
      .PC_W       (PC_W),
      .DATA_W     (DATA_W),
      .HIT_W      (HIT_W),
      .TMO_W      (TMO_W),
      .TMO_CYCLES (24'd20)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .pc_valid       (pc_valid),
      .pc_w           (pc_w),
      .chk_data       (chk_data),
      .cfg_chan_en    (cfg_chan_en),
      .cfg_addr       (cfg_addr),
      .cfg_expect     (cfg_expect),
      .cfg_mask       (cfg_mask),
      .cfg_hit_target (cfg_hit_target),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .timeout        (timeout),
      .fail_chan      (fail_chan),
      .chan_done      (chan_done),
      .cycle_cnt      (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after the next rising edge (drive and sample point).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic p, input logic f, input logic t,
                               input logic [2:0] fc, input logic [3:0] cd);
      exp_t e;
      e.pass = p; e.fail = f; e.timeout = t; e.fail_chan = fc; e.chan_done = cd;
      return e;
   endfunction

   task automatic cfg_clear();
      cfg_chan_en    = '0;
      cfg_addr       = '0;
      cfg_expect     = '0;
      cfg_mask       = '1;
      cfg_hit_target = '0;
      chk_data       = '0;
   endtask

   task automatic set_chan(input int c, input logic [31:0] addr, input logic [31:0] expv,
                           input logic [31:0] mask, input logic [7:0] target);
      cfg_addr[c*PC_W +: PC_W]         = addr;
      cfg_expect[c*DATA_W +: DATA_W]   = expv;
      cfg_mask[c*DATA_W +: DATA_W]     = mask;
      cfg_hit_target[c*HIT_W +: HIT_W] = target;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One retired instruction carrying the given probe vector.
   task automatic hit(input logic [31:0] pc, input logic [NCHAN*DATA_W-1:0] data);
      pc_valid = 1'b1;
      pc_w     = pc;
      chk_data = data;
      tick();
      pc_valid = 1'b0;
      chk_data = '0;
   endtask

   // Bounded wait for done, then compare the flags against the oldest queued result.
   task automatic wait_done(input string tag, output int n);
      exp_t e;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      e = sb.pop_front();
      check({tag, ".done"},      32'(done),      32'd1);
      check({tag, ".pass"},      32'(pass),      32'(e.pass));
      check({tag, ".fail"},      32'(fail),      32'(e.fail));
      check({tag, ".timeout"},   32'(timeout),   32'(e.timeout));
      check({tag, ".fail_chan"}, 32'(fail_chan), 32'(e.fail_chan));
      check({tag, ".chan_done"}, 32'(chan_done), 32'(e.chan_done));
      check({tag, ".busy"},      32'(busy),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      pc_valid = 1'b0;
      pc_w     = '0;
      cfg_clear();
      repeat (2) tick();
      check("rst.busy",      32'(busy),      32'd0);
      check("rst.done",      32'(done),      32'd0);
      check("rst.pass",      32'(pass),      32'd0);
      check("rst.fail",      32'(fail),      32'd0);
      check("rst.timeout",   32'(timeout),   32'd0);
      check("rst.chan_done", 32'(chan_done), 32'd0);
      check("rst.cycle_cnt", 32'(cycle_cnt), 32'd0);
      reset = 1'b0;
      tick();

      // Single channel, exact match on first hit.
      cfg_clear();
      set_chan(0, 32'h1c000020, 32'h5a, 32'hffffffff, 8'd1);
      cfg_chan_en = 4'b0001;
      do_start();
      check("t1.busy", 32'(busy), 32'd1);
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0001));
      hit(32'h1c000020, {96'h0, 32'h5a});
      check("t1.latency", 32'(done), 32'd1);
      wait_done("t1", n);
      // Terminal state ignores retirements and config changes.
      cfg_expect = '0;
      hit(32'h1c000020, {96'h0, 32'h5b});
      check("t1.hold_pass", 32'(pass), 32'd1);
      check("t1.hold_fail", 32'(fail), 32'd0);

      // Single-bit data error.
      cfg_clear();
      set_chan(0, 32'h1c000020, 32'h5a, 32'hffffffff, 8'd1);
      cfg_chan_en = 4'b0001;
      do_start();
      sb.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 4'b0000));
      hit(32'h1c000020, {96'h0, 32'h5b});
      wait_done("t2", n);

      // Same error bit masked out.
      set_chan(0, 32'h1c000020, 32'h5a, 32'hfffffffe, 8'd1);
      do_start();
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0001));
      hit(32'h1c000020, {96'h0, 32'h5b});
      wait_done("t2m", n);

      // Third occurrence triggers; earlier hits carry wrong data.
      cfg_clear();
      set_chan(0, 32'h1c000020, 32'h5a, 32'hffffffff, 8'd3);
      cfg_chan_en = 4'b0001;
      do_start();
      hit(32'h1c000020, {96'h0, 32'h00});
      check("t3.hit1_done", 32'(done), 32'd0);
      hit(32'h1c000020, {96'h0, 32'h00});
      check("t3.hit2_done", 32'(done), 32'd0);
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0001));
      hit(32'h1c000020, {96'h0, 32'h5a});
      wait_done("t3", n);

      // Three channels; ch1/ch2 share an address and mismatch together.
      cfg_clear();
      set_chan(0, 32'h100, 32'h11, 32'hffffffff, 8'd0);
      set_chan(1, 32'h200, 32'h22, 32'hffffffff, 8'd1);
      set_chan(2, 32'h200, 32'h33, 32'hffffffff, 8'd1);
      set_chan(3, 32'h200, 32'h44, 32'hffffffff, 8'd1);
      cfg_chan_en = 4'b0111;
      do_start();
      repeat (9) tick();
      hit(32'h100, {32'h0, 32'h0, 32'h0, 32'h11});
      check("t4.ch0_busy", 32'(busy),      32'd1);
      check("t4.ch0_done", 32'(chan_done), 32'h1);
      sb.push_back(mk(1'b0, 1'b1, 1'b0, 3'd1, 4'b0001));
      hit(32'h200, {32'h44, 32'h30, 32'h20, 32'h0});
      wait_done("t4", n);

      // Passing hit lands on the timeout cycle: pass wins.
      cfg_clear();
      set_chan(0, 32'h1c000020, 32'h5a, 32'hffffffff, 8'd1);
      cfg_chan_en = 4'b0001;
      do_start();
      repeat (19) tick();
      check("t5.cycle_cnt", 32'(cycle_cnt), 32'd19);
      check("t5.busy",      32'(busy),      32'd1);
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0001));
      hit(32'h1c000020, {96'h0, 32'h5a});
      wait_done("t5", n);
      check("t5.latency", 32'(n), 32'd0);

      // No channels enabled: one RUN cycle then PASS.
      cfg_clear();
      do_start();
      check("t7.busy", 32'(busy), 32'd1);
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 4'b0000));
      wait_done("t7", n);
      check("t7.cycles", 32'(n), 32'd1);

      // Timeout after 20 RUN cycles with no hits.
      cfg_clear();
      set_chan(0, 32'h1c000020, 32'h5a, 32'hffffffff, 8'd1);
      cfg_chan_en = 4'b0001;
      do_start();
      sb.push_back(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));
      wait_done("t6", n);
      check("t6.cycles",    32'(n),         32'd20);
      check("t6.cycle_cnt", 32'(cycle_cnt), 32'd19);

      // Restart clears everything.
      do_start();
      check("t6r.busy",      32'(busy),      32'd1);
      check("t6r.cycle_cnt", 32'(cycle_cnt), 32'd0);
      check("t6r.done",      32'(done),      32'd0);
      check("t6r.fail",      32'(fail),      32'd0);
      check("t6r.timeout",   32'(timeout),   32'd0);
      repeat (3) tick();
      check("t6r.count3", 32'(cycle_cnt), 32'd3);

      // Asynchronous reset mid-run.
      #2;
      reset = 1'b1;
      #1;
      check("ar.busy",      32'(busy),      32'd0);
      check("ar.done",      32'(done),      32'd0);
      check("ar.fail",      32'(fail),      32'd0);
      check("ar.cycle_cnt", 32'(cycle_cnt), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("ar.idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
